// File: rtl/l2_localmem_sweeper.sv
// l2_localmem_sweeper: post-reset invalidation sweep and flush engine that writes back dirty L2 lines and invalidates every set.
module l2_localmem_sweeper #(
  parameter int L2_SETS    = 512,
  parameter int L2_WAYS    = 8,
  parameter int TAG_BITS   = 15,
  parameter int STATE_BITS = 3,
  parameter int LINE_BITS  = 128,
  parameter int MODIFIED   = 3,
  parameter int INVALID    = 0,
  localparam int WAY_BITS  = $clog2(L2_WAYS),
  localparam int SET_BITS  = $clog2(L2_SETS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush_req,
  output logic                            init_done,
  output logic                            flush_done,
  output logic                            busy,
  output logic                            mem_rd_en,
  output logic                            mem_wr_rst,
  output logic [SET_BITS-1:0]             mem_set,
  input  logic [L2_WAYS*TAG_BITS-1:0]     mem_rd_tag,
  input  logic [L2_WAYS*STATE_BITS-1:0]   mem_rd_state,
  input  logic [L2_WAYS*LINE_BITS-1:0]    mem_rd_line,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [TAG_BITS+SET_BITS-1:0]    wb_addr,
  output logic [LINE_BITS-1:0]            wb_line
);
  typedef enum logic [2:0] {INIT, READY, RD, CAP, WB, INV, NEXT} state_t;
  state_t state, state_n;
  logic [SET_BITS-1:0] cnt, cnt_n;
  logic [L2_WAYS-1:0] mask, mask_n, dirty;
  logic [TAG_BITS-1:0] tag_q [L2_WAYS];
  logic [LINE_BITS-1:0] line_q [L2_WAYS];
  logic [WAY_BITS-1:0] way;
  logic last;
  assign last = cnt == SET_BITS'(L2_SETS - 1);
  // a line needs writeback only when it is both valid and modified
  always_comb begin
    dirty = '0;
    for (int i = 0; i < L2_WAYS; i++)
      dirty[i] = mem_rd_state[i*STATE_BITS +: STATE_BITS] != STATE_BITS'(INVALID) &&
                 mem_rd_state[i*STATE_BITS +: STATE_BITS] == STATE_BITS'(MODIFIED);
  end
  always_comb begin
    way = '0;
    for (int i = L2_WAYS - 1; i >= 0; i--)
      if (mask[i]) way = WAY_BITS'(i);
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mask_n  = mask;
    case (state)
      INIT: begin
        cnt_n   = cnt + 1'b1;
        state_n = last ? READY : INIT;
      end
      READY: if (flush_req) begin
        cnt_n   = '0;
        state_n = RD;
      end
      RD: state_n = CAP;
      CAP: begin
        mask_n  = dirty;
        state_n = |dirty ? WB : INV;
      end
      WB: if (wb_ready) begin
        mask_n[way] = 1'b0;
        state_n     = |mask_n ? WB : INV;
      end
      INV: state_n = NEXT;
      NEXT: begin
        cnt_n   = last ? cnt : cnt + 1'b1;
        state_n = last ? READY : RD;
      end
      default: state_n = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      cnt       <= '0;
      mask      <= '0;
      init_done <= 1'b0;
      for (int i = 0; i < L2_WAYS; i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= '0;
      end
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      mask  <= mask_n;
      if (state == INIT && last) init_done <= 1'b1;
      if (state == CAP)
        for (int i = 0; i < L2_WAYS; i++) begin
          tag_q[i]  <= mem_rd_tag[i*TAG_BITS +: TAG_BITS];
          line_q[i] <= mem_rd_line[i*LINE_BITS +: LINE_BITS];
        end
    end
  end
  // state resets to INIT, so mem_wr_rst is gated to stay low while reset is held
  assign mem_wr_rst = rst && (state == INIT || state == INV);
  assign mem_rd_en  = state == RD;
  assign mem_set    = cnt;
  assign busy       = state != READY;
  assign flush_done = state == NEXT && last;
  assign wb_valid   = state == WB;
  assign wb_addr    = {tag_q[way], cnt};
  assign wb_line    = line_q[way];
endmodule

// File: tb/tb_l2_localmem_sweeper.sv
// tb_l2_localmem_sweeper: directed vectors for init sweep, flush, writeback ordering/stall and reset abort.
module tb_l2_localmem_sweeper;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush_req = 1'b0;
  logic wb_ready = 1'b1;
  logic init_done, flush_done, busy, mem_rd_en, mem_wr_rst, wb_valid;
  logic [8:0] mem_set;
  logic [8*15-1:0] mem_rd_tag = '0;
  logic [8*3-1:0] mem_rd_state = '0;
  logic [8*128-1:0] mem_rd_line = '0;
  logic [23:0] wb_addr;
  logic [127:0] wb_line;
  logic [2:0] mem_st [512][8];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  l2_localmem_sweeper dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .init_done(init_done),
    .flush_done(flush_done), .busy(busy), .mem_rd_en(mem_rd_en),
    .mem_wr_rst(mem_wr_rst), .mem_set(mem_set), .mem_rd_tag(mem_rd_tag),
    .mem_rd_state(mem_rd_state), .mem_rd_line(mem_rd_line),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_line(wb_line)
  );

  function automatic logic [14:0] tag_of(input int s, input int w);
    return 15'(s * 37 + w * 1013 + 5);
  endfunction

  function automatic logic [127:0] line_of(input int s, input int w);
    return {32'(s), 32'(w), 32'hDEADBEEF, 32'(s * 131 + w)};
  endfunction

  // tag array model: read data appears the cycle after mem_rd_en
  always @(posedge clk) begin
    if (mem_rd_en)
      for (int w = 0; w < 8; w++) begin
        mem_rd_state[w*3 +: 3]    <= mem_st[mem_set][w];
        mem_rd_tag[w*15 +: 15]    <= tag_of(int'(mem_set), w);
        mem_rd_line[w*128 +: 128] <= line_of(int'(mem_set), w);
      end
    if (mem_wr_rst)
      for (int w = 0; w < 8; w++) mem_st[mem_set][w] = 3'd0;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int s;
    logic [7:0] dirty;
    logic [7:0] clean;
    int hold;
    int n;
    logic [31:0] ways;
  } vec_t;
  vec_t vecs[6];

  task automatic run_flush(input vec_t v);
    int stall = 0, seen = 0, last_hs = -10;
    bit done = 0;
    logic [23:0] held_a;
    logic [127:0] held_l;
    logic [2:0] wy;
    logic [2:0] st_or;
    for (int w = 0; w < 8; w++) mem_st[v.s][w] = v.dirty[w] ? 3'd3 : v.clean[w] ? 3'd1 : 3'd0;
    wb_ready = 1'b1;
    flush_req = 1'b1;
    @(negedge clk);
    chk("flush_start_rd", {mem_rd_en, mem_set}, {1'b1, 9'd0});
    flush_req = 1'b0;
    for (int c = 1; c < 5000 && !done; c++) begin
      @(negedge clk);
      if (wb_valid) begin
        if (stall < v.hold) begin
          wb_ready = 1'b0;
          if (stall == 0) begin
            held_a = wb_addr;
            held_l = wb_line;
          end else begin
            chk("wb_hold_addr", wb_addr, held_a);
            chk("wb_hold_line", wb_line, held_l);
          end
          stall++;
        end else begin
          wb_ready = 1'b1;
          wy = seen < 8 ? v.ways[4*seen +: 3] : 3'd0;
          chk("wb_addr", wb_addr, {tag_of(v.s, int'(wy)), 9'(v.s)});
          chk("wb_line", wb_line, line_of(v.s, int'(wy)));
          if (seen > 0) chk("wb_back_to_back", c, last_hs + 1);
          last_hs = c;
          seen++;
        end
      end
      if (mem_wr_rst && mem_set == 9'(v.s)) begin
        chk("inv_after_wb", seen, v.n);
        if (v.n > 0) chk("inv_timing", c, last_hs + 1);
      end
      if (flush_done) done = 1;
    end
    chk("flush_done_seen", done, 1);
    chk("wb_count", seen, v.n);
    st_or = '0;
    for (int w = 0; w < 8; w++) st_or = st_or | mem_st[v.s][w];
    chk("set_invalidated", st_or, 3'd0);
    @(negedge clk);
    chk("ready_after_flush", {busy, flush_done}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad, c, wbs, ovl;
    bit found;
    vecs[0] = '{5,   8'h44, 8'h00, 0,  2, 32'h62};
    vecs[1] = '{5,   8'h44, 8'h00, 10, 2, 32'h62};
    vecs[2] = '{0,   8'h00, 8'hFF, 0,  0, 32'h0};
    vecs[3] = '{200, 8'hFF, 8'h00, 0,  8, 32'h76543210};
    vecs[4] = '{511, 8'h80, 8'h7F, 0,  1, 32'h7};
    vecs[5] = '{37,  8'h09, 8'h06, 3,  2, 32'h30};
    for (int s = 0; s < 512; s++)
      for (int w = 0; w < 8; w++) mem_st[s][w] = 3'd1;

    repeat (2) @(negedge clk);
    chk("rst_outputs", {busy, init_done, flush_done, wb_valid, mem_rd_en, mem_wr_rst, mem_set},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0});
    chk("rst_wb_addr", wb_addr, 24'd0);
    flush_req = 1'b1;
    rst = 1'b1;
    #1;
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      if (k > 0) @(negedge clk);
      if (mem_wr_rst !== 1'b1 || mem_set !== 9'(k) || init_done !== 1'b0 || mem_rd_en !== 1'b0) bad++;
    end
    chk("init_sweep_errors", bad, 0);
    @(negedge clk);
    chk("init_done_513", {init_done, busy, mem_wr_rst, mem_rd_en}, 4'b1000);
    @(negedge clk);
    chk("flush_during_init_rd", {mem_rd_en, mem_wr_rst, mem_set, busy}, {1'b1, 1'b0, 9'd0, 1'b1});
    flush_req = 1'b0;
    c = 1;
    wbs = 0;
    ovl = 0;
    while (!flush_done && c < 3000) begin
      @(negedge clk);
      c++;
      if (wb_valid) wbs++;
      if (mem_rd_en && mem_wr_rst) ovl++;
    end
    chk("clean_flush_cycles", c, 2048);
    chk("clean_flush_no_wb", wbs, 0);
    chk("rd_wr_overlap", ovl, 0);
    @(negedge clk);
    chk("flush_done_pulse", {flush_done, busy}, 2'b00);

    for (int i = 0; i < 6; i++) run_flush(vecs[i]);

    mem_st[100][3] = 3'd3;
    wb_ready = 1'b0;
    flush_req = 1'b1;
    found = 0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clk);
      flush_req = 1'b0;
      if (wb_valid) found = 1;
    end
    chk("abort_wb_seen", {found, mem_set}, {1'b1, 9'd100});
    rst = 1'b0;
    #1;
    chk("abort_async", {wb_valid, busy, mem_wr_rst, mem_rd_en, mem_set, init_done},
        {1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0});
    @(negedge clk);
    rst = 1'b1;
    wb_ready = 1'b1;
    #1;
    chk("restart_set0", {mem_wr_rst, mem_set}, {1'b1, 9'd0});
    @(negedge clk);
    chk("restart_set1", {mem_wr_rst, mem_set, init_done}, {1'b1, 9'd1, 1'b0});
    found = 0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      if (init_done) found = 1;
    end
    chk("reinit_done", {found, busy}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
